// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration interface: per-master request/grant pairs, the
// shared transaction strobes the arbiter observes, and its status outputs.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] request;
    logic                   begin_transactionIN;
    logic                   end_transactionIN;
    logic                   errorIN;
    logic [NUM_MASTERS-1:0] granted;
    logic [ID_W-1:0]        owner_id;
    logic                   bus_owned;
    logic                   timeout_error;
    logic [ID_W-1:0]        timeout_id;

    // Bus-master side: raises requests and drives the shared strobes.
    modport master (
        output request, begin_transactionIN, end_transactionIN, errorIN,
        input  granted, owner_id, bus_owned, timeout_error, timeout_id
    );

    // Arbiter side.
    modport slave (
        input  request, begin_transactionIN, end_transactionIN, errorIN,
        output granted, owner_id, bus_owned, timeout_error, timeout_id
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with grant and busy timeouts.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | no owner, arbitrating every cycle
// S_GRANT   | owner granted, waiting for begin_transaction
// S_BUSY    | transaction in flight, waiting for end/error
// S_RELEASE | one-cycle bus turnaround (granted=0), arbitrating
module bus_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int GRANT_TIMEOUT = 16,
    parameter int BUSY_TIMEOUT  = 1024
) (
    input  logic          i_clock,
    input  logic          i_reset,
    bus_arbiter_if.slave  bus
);
    localparam int ID_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int MAX_T = (GRANT_TIMEOUT > BUSY_TIMEOUT) ? GRANT_TIMEOUT : BUSY_TIMEOUT;
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CNT_W-1:0] GT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_granted;
    logic [ID_W-1:0]        r_owner_id;
    logic                   r_bus_owned;
    logic                   r_timeout_error;
    logic [ID_W-1:0]        r_timeout_id;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [CNT_W-1:0]       r_cnt;

    logic [2*NUM_MASTERS-1:0] w_req2;
    logic [NUM_MASTERS-1:0]   w_rot;
    logic [ID_W-1:0]          w_off;
    logic [ID_W:0]            w_sum;
    logic                     w_found;
    logic [ID_W-1:0]          w_winner;
    logic [NUM_MASTERS-1:0]   w_onehot;
    logic [ID_W-1:0]          w_next_ptr;
    logic                     w_leave;
    logic                     w_tmo;
    logic                     w_to_busy;

    // Requests rotated so bit 0 is the master at rr_ptr; lowest set bit wins.
    always_comb begin
        w_req2  = {bus.request, bus.request};
        w_rot   = NUM_MASTERS'(w_req2 >> r_rr_ptr);
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = ID_W'(k);
            end
        end
        w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_winner = (w_sum >= (ID_W+1)'(NUM_MASTERS)) ?
                   ID_W'(w_sum - (ID_W+1)'(NUM_MASTERS)) : w_sum[ID_W-1:0];
        w_onehot = NUM_MASTERS'(1) << w_winner;
        w_next_ptr = (r_owner_id == ID_W'(NUM_MASTERS - 1)) ? '0 : r_owner_id + ID_W'(1);
    end

    // Exit decisions for GRANT/BUSY; begin beats a same-cycle request drop or timeout.
    always_comb begin
        w_leave   = 1'b0;
        w_tmo     = 1'b0;
        w_to_busy = 1'b0;
        case (r_state)
            S_GRANT: begin
                if (bus.begin_transactionIN && bus.end_transactionIN) begin
                    w_leave = 1'b1;
                end else if (bus.begin_transactionIN) begin
                    w_to_busy = 1'b1;
                end else if (!bus.request[r_owner_id]) begin
                    w_leave = 1'b1;
                end else if (r_cnt == GT_LAST) begin
                    w_leave = 1'b1;
                    w_tmo   = 1'b1;
                end
            end
            S_BUSY: begin
                if (bus.end_transactionIN || bus.errorIN) begin
                    w_leave = 1'b1;
                end else if (r_cnt == BT_LAST) begin
                    w_leave = 1'b1;
                    w_tmo   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Arbiter FSM with registered grant/status outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_granted       <= '0;
            r_owner_id      <= '0;
            r_bus_owned     <= 1'b0;
            r_timeout_error <= 1'b0;
            r_timeout_id    <= '0;
            r_rr_ptr        <= '0;
            r_cnt           <= '0;
        end else begin
            r_timeout_error <= w_tmo;
            if (w_tmo) begin
                r_timeout_id <= r_owner_id;
            end
            case (r_state)
                S_IDLE, S_RELEASE: begin
                    r_cnt <= '0;
                    if (w_found) begin
                        r_state     <= S_GRANT;
                        r_granted   <= w_onehot;
                        r_owner_id  <= w_winner;
                        r_bus_owned <= 1'b1;
                    end else begin
                        r_state     <= S_IDLE;
                        r_granted   <= '0;
                        r_bus_owned <= 1'b0;
                    end
                end
                S_GRANT, S_BUSY: begin
                    if (w_leave) begin
                        r_state     <= S_RELEASE;
                        r_granted   <= '0;
                        r_bus_owned <= 1'b0;
                        r_cnt       <= '0;
                        r_rr_ptr    <= w_next_ptr;
                    end else if (w_to_busy) begin
                        r_state <= S_BUSY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.granted       = r_granted;
    assign bus.owner_id      = r_owner_id;
    assign bus.bus_owned     = r_bus_owned;
    assign bus.timeout_error = r_timeout_error;
    assign bus.timeout_id    = r_timeout_id;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_bus_arbiter;
    localparam int N  = 4;
    localparam int GT = 16;
    localparam int BT = 1024;

    logic clk = 1'b0;
    logic rst;

    // Free-running clock.
    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_MASTERS(N)) bif();

    bus_arbiter #(
        .NUM_MASTERS  (N),
        .GRANT_TIMEOUT(GT),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bif.slave)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    // Reference model: who owns the bus, whether it has begun, how long it has held it.
    int m_own;
    bit m_started;
    int m_held;
    int m_ptr;
    int m_last;
    bit m_pulse;
    int m_tid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] req;
        bit leave;
        req   = bif.request;
        leave = 1'b0;
        if (rst) begin
            m_own = -1; m_started = 0; m_held = 0; m_ptr = 0;
            m_last = 0; m_pulse = 0; m_tid = 0;
            return;
        end
        m_pulse = 0;
        if (m_own < 0) begin
            for (int i = 0; i < N; i++) begin
                if (req[(m_ptr + i) % N]) begin
                    m_own     = (m_ptr + i) % N;
                    m_last    = m_own;
                    m_started = 0;
                    m_held    = 0;
                    break;
                end
            end
        end else begin
            m_held++;
            if (!m_started) begin
                if (bif.begin_transactionIN && bif.end_transactionIN) leave = 1;
                else if (bif.begin_transactionIN) begin m_started = 1; m_held = 0; end
                else if (!req[m_own]) leave = 1;
                else if (m_held == GT) begin leave = 1; m_pulse = 1; end
            end else begin
                if (bif.end_transactionIN || bif.errorIN) leave = 1;
                else if (m_held == BT) begin leave = 1; m_pulse = 1; end
            end
            if (leave) begin
                if (m_pulse) m_tid = m_own;
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg;
        eg = '0;
        if (m_own >= 0) eg[m_own] = 1'b1;
        chk("granted",       32'(bif.granted),       32'(eg));
        chk("bus_owned",     32'(bif.bus_owned),     32'(m_own >= 0));
        chk("owner_id",      32'(bif.owner_id),      32'(m_last));
        chk("timeout_error", 32'(bif.timeout_error), 32'(m_pulse));
        chk("timeout_id",    32'(bif.timeout_id),    32'(m_tid));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic [N-1:0] req, input logic b, input logic e, input logic er);
        bif.request             = req;
        bif.begin_transactionIN = b;
        bif.end_transactionIN   = e;
        bif.errorIN             = er;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in('0, 0, 0, 0);
        cycle();
        rst = 1'b0;
    endtask

    // Safety net so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_in('0, 0, 0, 0);
        @(negedge clk);

        phase = "reset";
        do_reset();
        chk("rst_granted", 32'(bif.granted), 32'h0);
        chk("rst_owned",   32'(bif.bus_owned), 32'h0);
        chk("rst_tmo",     32'(bif.timeout_error), 32'h0);

        phase = "single";
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            if (c >= 1) begin
                chk("grant_seq", 32'(bif.granted), (c <= 10) ? 32'h2 : 32'h0);
                chk("no_tmo",    32'(bif.timeout_error), 32'h0);
            end
            set_in((c < 10) ? 4'b0010 : 4'b0000, c == 3, c == 10, 0);
            cycle();
        end

        phase = "round_robin";
        do_reset();
        set_in(4'b1111, 0, 0, 0);
        cycle();
        chk("rr_first", 32'(bif.granted), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            set_in(4'b1111, 1, 0, 0); cycle();
            set_in(4'b1111, 0, 1, 0); cycle();
            set_in(4'b1111, 0, 0, 0);
            chk("rr_gap", 32'(bif.granted), 32'h0);
            cycle();
            chk("rr_order", 32'(bif.granted), 32'(1 << (k % 4)));
        end

        phase = "grant_timeout";
        do_reset();
        set_in(4'b0100, 0, 0, 0);
        cycle();
        set_in(4'b0101, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            chk("gt_hold", 32'(bif.granted), 32'h4);
            chk("gt_nopulse", 32'(bif.timeout_error), 32'h0);
            if (i < 15) cycle();
        end
        cycle();
        chk("gt_release", 32'(bif.granted), 32'h0);
        chk("gt_pulse",   32'(bif.timeout_error), 32'h1);
        chk("gt_id",      32'(bif.timeout_id), 32'h2);
        cycle();
        chk("gt_next",    32'(bif.granted), 32'h1);
        chk("gt_onepulse", 32'(bif.timeout_error), 32'h0);

        phase = "busy_timeout";
        do_reset();
        set_in(4'b0001, 0, 0, 0); cycle();
        set_in(4'b0001, 1, 0, 0); cycle();
        set_in(4'b0000, 0, 0, 0);
        for (int i = 1; i <= 1023; i++) begin
            cycle();
            if (i == 1023) chk("bt_hold", 32'(bif.granted), 32'h1);
        end
        cycle();
        chk("bt_release", 32'(bif.granted), 32'h0);
        chk("bt_pulse",   32'(bif.timeout_error), 32'h1);
        chk("bt_id",      32'(bif.timeout_id), 32'h0);

        phase = "error_end";
        do_reset();
        set_in(4'b0010, 0, 0, 0); cycle();
        set_in(4'b0010, 1, 0, 0); cycle();
        set_in(4'b0010, 0, 0, 0); cycle(); cycle();
        set_in(4'b0000, 0, 0, 1); cycle();
        set_in(4'b0000, 0, 0, 0);
        chk("err_release", 32'(bif.granted), 32'h0);
        chk("err_no_tmo",  32'(bif.timeout_error), 32'h0);

        phase = "begin_end_same";
        do_reset();
        set_in(4'b0001, 0, 0, 0); cycle();
        set_in(4'b0000, 1, 1, 0); cycle();
        set_in(4'b0000, 0, 0, 0);
        chk("be_release", 32'(bif.granted), 32'h0);
        chk("be_owned",   32'(bif.bus_owned), 32'h0);

        phase = "drop_request";
        do_reset();
        set_in(4'b0100, 0, 0, 0); cycle(); cycle();
        set_in(4'b0000, 0, 0, 0); cycle();
        chk("drop_release", 32'(bif.granted), 32'h0);
        chk("drop_no_tmo",  32'(bif.timeout_error), 32'h0);

        phase = "reset_mid_busy";
        do_reset();
        set_in(4'b1010, 0, 0, 0); cycle();
        chk("rb_first", 32'(bif.granted), 32'h2);
        set_in(4'b1010, 1, 0, 0); cycle();
        set_in(4'b1010, 0, 1, 0); cycle();
        set_in(4'b1010, 0, 0, 0); cycle();
        chk("rb_second", 32'(bif.granted), 32'h8);
        set_in(4'b1010, 1, 0, 0); cycle();
        set_in(4'b1010, 0, 0, 0);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("rb_drop", 32'(bif.granted), 32'h0);
        cycle();
        chk("rb_lowest", 32'(bif.granted), 32'h2);

        phase = "random";
        do_reset();
        begin
            logic [N-1:0] req;
            req = '0;
            for (int t = 0; t < 4000; t++) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 19) == 0) req[i] = ~req[i];
                end
                set_in(req, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 29) == 0);
                rst = ($urandom_range(0, 599) == 0);
                cycle();
            end
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared Gecko5Education bus. It takes one `request` line per bus master (JTAG DMA, CPU, etc.) and returns a one-hot `granted` vector. It tracks each transaction from `begin_transaction` to `end_transaction` and revokes stalled grants with timeouts. It sits directly downstream of the `request`/`granted` pair of each master and observes the shared bus control lines.

## Interface
- `NUM_MASTERS`, 4: number of requesters, 2..16.
- `GRANT_TIMEOUT`, 16: cycles a granted master may take to assert `begin_transaction`.
- `BUSY_TIMEOUT`, 1024: cycles a transaction may last before the arbiter forcibly ends it.
- `clock` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `request` in NUM_MASTERS: bit i set = master i wants the bus; level-held until served.
- `begin_transactionIN` in 1: shared-bus begin strobe (OR of all masters).
- `end_transactionIN` in 1: shared-bus end strobe (master or slave).
- `errorIN` in 1: shared-bus error strobe.
- `granted` out NUM_MASTERS: one-hot grant, registered; all zero when no owner.
- `owner_id` out clog2(NUM_MASTERS): index of the current or last owner.
- `bus_owned` out 1: high in GRANT and BUSY.
- `timeout_error` out 1: one-cycle pulse when a grant or transaction is revoked by timeout.
- `timeout_id` out clog2(NUM_MASTERS): master that timed out; held until the next timeout.

## Operation
- States: IDLE, GRANT, BUSY, RELEASE.
- Arbitration runs in IDLE and RELEASE:
  - Search `request` starting at `rr_ptr`, upward with wrap-around; the first set bit wins.
  - On a winner: next state GRANT, `granted` = one-hot(winner), `owner_id` = winner.
  - No requests: go to or stay in IDLE.
- GRANT:
  - `begin_transactionIN`=1 → BUSY.
  - `begin_transactionIN` and `end_transactionIN` both 1 in the same cycle → RELEASE; the transaction is treated as complete.
  - Owner's `request` drops before begin → RELEASE, with no error.
  - Counter reaches GRANT_TIMEOUT−1 with no begin → RELEASE and pulse `timeout_error`.
- BUSY:
  - `end_transactionIN`=1 or `errorIN`=1 → RELEASE.
  - Owner's `request` dropping is ignored.
  - Counter reaches BUSY_TIMEOUT−1 with no end → RELEASE and pulse `timeout_error`.
- RELEASE: `granted`=0 for exactly this cycle (bus turnaround). Arbitration runs in the same cycle.
- Whenever GRANT or BUSY is left, `rr_ptr` ← (owner_id+1) mod NUM_MASTERS. This covers timeouts and dropped requests, so a stalled master cannot hog the bus.
- Timeout counter:
  - Width clog2(max(GRANT_TIMEOUT, BUSY_TIMEOUT)).
  - Cleared on every state change; increments each cycle in GRANT or BUSY.
- `request` bits of non-owners are ignored during GRANT/BUSY (no preemption).
- Reset values: state IDLE, `granted`=0, `owner_id`=0, `bus_owned`=0, `timeout_error`=0, `timeout_id`=0, `rr_ptr`=0, counter=0.
- Reset mid-transaction:
  - Grant drops in the cycle after `reset` is sampled high.
  - The arbiter does not emit `end_transaction`; bus cleanup is the master's job.

## Timing
- Request to grant: `request[i]` sampled at edge t in IDLE → `granted[i]`=1 after edge t (visible in cycle t+1).
- Grant hold: `granted` stays constant through GRANT and BUSY.
- End to release:
  - `end_transactionIN` at cycle t → `granted`=0 in cycle t+1 (RELEASE).
  - Next grant visible in cycle t+2 if any request is pending.
- Back-to-back ownership: at most 1 dead cycle between two owners.
- Timeout pulse:
  - `timeout_error` is high in the RELEASE cycle that follows the timeout.
  - `timeout_id` updates in the same cycle.
- GRANT timeout fires when the master has been granted GRANT_TIMEOUT cycles with no begin. Same rule for BUSY with BUSY_TIMEOUT.
- Output registering: `granted`, `bus_owned` and `owner_id` are registered; there is no combinational path from `request` to `granted`.

## Test plan
- Single requester:
  - Stimulus: `request`=0010 at cycle 0; begin at cycle 3; end at cycle 10.
  - Required: `granted`=0010 in cycles 1..10; 0000 in cycle 11; `timeout_error` never asserted.
- Round-robin fairness:
  - Stimulus: `request`=1111 held; every transaction is 1 begin + 1 end.
  - Required: grant order 0,1,2,3,0; exactly 1 zero-`granted` cycle between consecutive owners.
- Grant timeout:
  - Stimulus: `request`=0100, no begin.
  - Required: `granted`=0100 for 16 cycles, then 0000 with `timeout_error`=1 and `timeout_id`=2.
  - Then with `request`=0101 still held: master 0 is granted next.
- Busy timeout and error end:
  - Stimulus: begin with no end for 1024 cycles.
  - Required: forced release with `timeout_error` pulse.
  - Separately: `errorIN` during BUSY → release the next cycle, no `timeout_error`.
- Edge events:
  - Begin+end in the same GRANT cycle → RELEASE.
  - Owner drops `request` in GRANT → release without error.
  - `reset` asserted mid-BUSY → `granted`=0 and `rr_ptr`=0 the next cycle; the following grant goes to the lowest pending index.
